// File: rtl/sseg_pkg.sv
// Shared types, constants and the hex-to-segment table for the seven-segment scan controller.
package sseg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  typedef enum logic [0:0] {
    StBlank = 1'b0,
    StDrive = 1'b1
  } state_e;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        lzb;
  } disp_t;

  // Active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern.
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = hex7(nibble_i);
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit seven-segment scan controller with blanking gap and double-buffered update port.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] upd_digits,
  input  logic [3:0]  upd_dp,
  input  logic [3:0]  upd_en,
  input  logic        upd_lzb,
  output logic [3:0]  an,
  output logic [7:0]  sseg,
  output logic        frame_done
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax   = CntW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] BlankLim = CntW'(BLANK_CYC);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  state_e          state_q, state_d;
  logic            pend_q, pend_d;
  disp_t           pbuf_q, pbuf_d;
  disp_t           abuf_q, abuf_d;
  logic [3:0]      an_q, an_d;
  logic [7:0]      sseg_q, sseg_d;
  logic            frame_done_q, frame_done_d;

  logic            frame_end;
  logic            upper_zero;
  logic            lz_blank;
  logic            shown;
  logic [6:0]      seg_pat;

  sseg_hex_decode u_hex_decode (
    .nibble_i (abuf_q.digits[{idx_q, 2'b00} +: 4]),
    .seg_o    (seg_pat)
  );

  always_comb begin
    frame_end = (cnt_q == CntMax) && (idx_q == 2'd3);
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    state_d      = (cnt_d < BlankLim) ? StBlank : StDrive;
    frame_done_d = (cnt_d == CntMax) && (idx_d == 2'd3);
  end

  // Commit only ever happens with pend_q set and accept only with it clear, so they never collide.
  always_comb begin
    pend_d = pend_q;
    pbuf_d = pbuf_q;
    abuf_d = abuf_q;
    if (frame_end && pend_q) begin
      abuf_d = pbuf_q;
      pend_d = 1'b0;
    end else if (upd_valid && !pend_q) begin
      pbuf_d = '{digits: upd_digits, dp: upd_dp, en: upd_en, lzb: upd_lzb};
      pend_d = 1'b1;
    end
  end

  always_comb begin
    upper_zero = (abuf_q.digits >> {idx_q, 2'b00}) == 16'h0000;
    lz_blank   = abuf_q.lzb && (idx_q != 2'd0) && upper_zero && !abuf_q.dp[idx_q];
    shown      = abuf_q.en[idx_q] && !lz_blank;
    an_d       = AN_OFF;
    sseg_d     = SEG_OFF;
    if (state_q == StDrive && shown) begin
      an_d   = ~(4'b0001 << idx_q);
      sseg_d = {~abuf_q.dp[idx_q], seg_pat};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      state_q      <= StBlank;
      pend_q       <= 1'b0;
      pbuf_q       <= '0;
      abuf_q       <= '0;
      an_q         <= AN_OFF;
      sseg_q       <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      pend_q       <= pend_d;
      pbuf_q       <= pbuf_d;
      abuf_q       <= abuf_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign upd_ready  = !pend_q;
  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Randomized scoreboard bench for sseg_scan_ctrl against a time-based display model.
module tb_sseg_scan_ctrl;

  localparam int TD = 10;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_digits;
  logic [3:0]  upd_dp;
  logic [3:0]  upd_en;
  logic        upd_lzb;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_done;

  sseg_scan_ctrl #(
    .TICK_DIV  (TD),
    .BLANK_CYC (BC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_digits (upd_digits),
    .upd_dp     (upd_dp),
    .upd_en     (upd_en),
    .upd_lzb    (upd_lzb),
    .an         (an),
    .sseg       (sseg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [7:0] sseg;
    logic       rdy;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Display contents as seen by the viewer, and the update waiting for the next frame.
  logic [15:0] m_dig, p_dig;
  logic [3:0]  m_dp, m_en, p_dp, p_en;
  logic        m_lzb, p_lzb;
  bit          m_pend;
  bit          started = 0;
  int          t;

  function automatic bit visible(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en,
                                 input logic lzb, input int k);
    bit lz;
    lz = lzb && (k != 0) && ((d >> (4 * k)) == 16'h0) && !dp[k];
    return en[k] && !lz;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int   pos;
    int   slot;
    bit   acc;
    if (reset) begin
      t = 0;
      m_dig = '0; m_dp = '0; m_en = '0; m_lzb = 0;
      p_dig = '0; p_dp = '0; p_en = '0; p_lzb = 0;
      m_pend = 0;
      started = 1;
      e = '{an: 4'hF, sseg: 8'hFF, rdy: 1'b1, fd: 1'b0};
    end else if (started) begin
      pos  = t % TD;
      slot = (t / TD) % 4;
      e.an   = 4'hF;
      e.sseg = 8'hFF;
      if (pos >= BC && visible(m_dig, m_dp, m_en, m_lzb, slot)) begin
        e.an   = ~(4'b0001 << slot);
        e.sseg = {~m_dp[slot], hex_tab[(m_dig >> (4 * slot)) & 16'hF]};
      end
      acc = upd_valid && !m_pend;
      if (pos == TD - 1 && slot == 3 && m_pend) begin
        m_dig = p_dig; m_dp = p_dp; m_en = p_en; m_lzb = p_lzb;
        m_pend = 0;
      end
      if (acc) begin
        p_dig = upd_digits; p_dp = upd_dp; p_en = upd_en; p_lzb = upd_lzb;
        m_pend = 1;
      end
      t++;
      e.fd  = ((t % TD) == TD - 1) && (((t / TD) % 4) == 3);
      e.rdy = !m_pend;
    end
    if (started) q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (an !== e.an || sseg !== e.sseg || upd_ready !== e.rdy || frame_done !== e.fd ||
          $countones(~an) > 1) begin
        miscompares++;
        $display("FAIL outputs @%0t: an=%h sseg=%h rdy=%b fd=%b, required an=%h sseg=%h rdy=%b fd=%b",
                 $time, an, sseg, upd_ready, frame_done, e.an, e.sseg, e.rdy, e.fd);
      end
    end
  end

  // Called at a negedge; holds upd_valid until the controller can take it.
  task automatic send(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en,
                      input logic lzb);
    int n = 0;
    upd_digits = d; upd_dp = dp; upd_en = en; upd_lzb = lzb;
    upd_valid  = 1'b1;
    while (!upd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!upd_ready) begin
      miscompares++;
      $display("FAIL handshake: upd_ready=%b after %0d cycles, required 1", upd_ready, n);
    end
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [15:0] d;
    reset = 1'b1;
    upd_valid = 1'b0; upd_digits = '0; upd_dp = '0; upd_en = '0; upd_lzb = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(85);

    send(16'h1234, 4'b0001, 4'b1111, 1'b0);
    idle(90);
    send(16'hABCD, 4'b1010, 4'b1111, 1'b0);
    send(16'hEF09, 4'b0000, 4'b1011, 1'b0);  // held while the previous one is pending
    idle(90);
    send(16'h0042, 4'b0000, 4'b1111, 1'b1);
    idle(90);
    send(16'h0042, 4'b0100, 4'b1111, 1'b1);
    idle(90);

    for (int i = 0; i < 25; i++) begin
      d = 16'($urandom());
      if ($urandom_range(0, 1) == 1) d = d >> (4 * $urandom_range(1, 4));
      send(d, 4'($urandom()), ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF,
           1'($urandom()));
      idle($urandom_range(0, 60));
    end
    idle(60);

    send(16'h5678, 4'b0000, 4'b1111, 1'b0);
    idle(5);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
